mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer that shares one unified instruction/data memory between the fetch port and the data-memory port of the MIPS-subset core. It accepts request/acknowledge transactions from both ports, grants one at a time with round-robin tie-breaking, and drives a fixed-latency synchronous memory. It returns read data or write completion to the winner. It sits between the fetch and load/store logic (driven by the decoder's `dmWe`) and the memory macro.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Function : Fetch, data and memory-macro signals of the unified memory arbiter.
//  Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              imReq;
    logic [ADDR_W-1:0] imAddr;
    logic [DATA_W-1:0] imRData;
    logic              imAck;

    logic              dmReq;
    logic              dmWe;
    logic [ADDR_W-1:0] dmAddr;
    logic [DATA_W-1:0] dmWData;
    logic [DATA_W-1:0] dmRData;
    logic              dmAck;

    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;

    // Arbiter side
    modport slave (
        input  imReq, imAddr, dmReq, dmWe, dmAddr, dmWData, memRData,
        output imRData, imAck, dmRData, dmAck, memEn, memWe, memAddr, memWData
    );

    // Requesters and memory side
    modport master (
        output imReq, imAddr, dmReq, dmWe, dmAddr, dmWData, memRData,
        input  imRData, imAck, dmRData, dmAck, memEn, memWe, memAddr, memWData
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Function : Round-robin fetch/data arbiter sequencing one fixed-latency memory.
//  Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy
);

    localparam int CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_IM = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    state_e            state_q,     state_d;
    port_e             gnt_q,       gnt_d;
    port_e             last_gnt_q,  last_gnt_d;
    logic              we_q,        we_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              im_ack_q,    im_ack_d;
    logic              dm_ack_q,    dm_ack_d;
    logic [DATA_W-1:0] im_rdata_q,  im_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              busy_q,      busy_d;
    logic              pick_dm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= PORT_IM;
            last_gnt_q  <= PORT_IM;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            im_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            im_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            im_ack_q    <= im_ack_d;
            dm_ack_q    <= dm_ack_d;
            im_rdata_q  <= im_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        im_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        im_rdata_d  = im_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        pick_dm     = bus.dmReq && (!bus.imReq || (last_gnt_q == PORT_IM));

        case (state_q)
            S_IDLE: begin
                if (bus.imReq || bus.dmReq) begin
                    state_d  = S_ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_dm) begin
                        gnt_d       = PORT_DM;
                        we_d        = bus.dmWe;
                        mem_we_d    = bus.dmWe;
                        mem_addr_d  = bus.dmAddr;
                        mem_wdata_d = bus.dmWData;
                    end else begin
                        gnt_d      = PORT_IM;
                        we_d       = 1'b0;
                        mem_addr_d = bus.imAddr;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d      = CNT_W'(LAT);
                last_gnt_d = gnt_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    if (gnt_q == PORT_IM) begin
                        im_rdata_d = bus.memRData;
                        im_ack_d   = 1'b1;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = bus.memRData;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.memEn    = mem_en_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWData = mem_wdata_q;
    assign bus.imAck    = im_ack_q;
    assign bus.dmAck    = dm_ack_q;
    assign bus.imRData  = im_rdata_q;
    assign bus.dmRData  = dm_rdata_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Function : Directed and random checks of mem_arbiter against a transaction model.
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset1 = 1'b1;
    logic busy;
    logic busy1;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(1)) u_dut_lat1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory environment: 64 words, read data LAT cycles after the strobe
    logic [31:0] mem_arr [64];
    logic [31:0] rpipe [1:LAT];
    bit          mem_inited;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_val(i);
            mem_inited <= 1'b1;
        end else if (bus.memEn && bus.memWe) begin
            mem_arr[bus.memAddr[7:2]] <= bus.memWData;
        end
        rpipe[1] <= (bus.memEn === 1'b1 && bus.memWe === 1'b0) ? mem_arr[bus.memAddr[7:2]] : $urandom;
        for (int i = 2; i <= LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.memRData = rpipe[LAT];

    logic [31:0] rp1;
    always @(posedge clk)
        rp1 <= (bus1.memEn === 1'b1 && bus1.memWe === 1'b0) ? init_val(int'(bus1.memAddr[7:2])) : $urandom;
    assign bus1.memRData = rp1;

    // Transaction-level model: a grant at cycle g strobes memory at g+1,
    // acks at g+LAT+2 and frees the arbiter from g+LAT+3 on.
    logic [31:0] ref_mem [64];
    bit          seen_rst;
    int          m_g    = -100;
    int          m_free = 0;
    bit          m_port, m_we, m_last, pick;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] e_im_rd = '0, e_dm_rd = '0, e_maddr = '0, e_mwd = '0;
    bit          m_im_acked, m_dm_acked;
    bit          e_en, e_ack, e_busy;
    int          c, idx;

    always @(negedge clk) begin
        c = cyc;
        if (!seen_rst) begin
            if (reset) begin
                seen_rst = 1'b1;
                for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
            end
        end else begin
            e_en   = (c == m_g + 1);
            e_ack  = (c == m_g + LAT + 2);
            e_busy = (c > m_g) && (c <= m_g + LAT + 2);
            if (e_ack && !m_port) e_im_rd = m_rd;
            if (e_ack && m_port && !m_we) e_dm_rd = m_rd;
            if (e_en) begin
                e_maddr = m_addr;
                if (m_port) e_mwd = m_wdata;
            end
            check_eq("imAck",    bus.imAck,    e_ack && !m_port);
            check_eq("dmAck",    bus.dmAck,    e_ack && m_port);
            check_eq("ack_excl", bus.imAck & bus.dmAck, 0);
            check_eq("memEn",    bus.memEn,    e_en);
            check_eq("memWe",    bus.memWe,    e_en && m_we);
            check_eq("busy",     busy,         e_busy);
            check_eq("imRData",  bus.imRData,  e_im_rd);
            check_eq("dmRData",  bus.dmRData,  e_dm_rd);
            check_eq("memAddr",  bus.memAddr,  e_maddr);
            check_eq("memWData", bus.memWData, e_mwd);
            m_im_acked = e_ack && !m_port;
            m_dm_acked = e_ack && m_port;
            if (reset) begin
                m_g = -100; m_free = 0; m_last = 1'b0;
                e_im_rd = '0; e_dm_rd = '0; e_maddr = '0; e_mwd = '0;
                m_im_acked = 1'b0; m_dm_acked = 1'b0;
            end else if (c >= m_free && (bus.imReq || bus.dmReq)) begin
                pick    = bus.dmReq && (!bus.imReq || !m_last);
                m_port  = pick;
                m_last  = pick;
                m_g     = c;
                m_free  = c + LAT + 3;
                m_addr  = pick ? bus.dmAddr : bus.imAddr;
                m_we    = pick && bus.dmWe;
                m_wdata = bus.dmWData;
                idx     = int'(m_addr[7:2]);
                if (m_we) ref_mem[idx] = m_wdata;
                m_rd    = ref_mem[idx];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_im();
        bus.imReq  = 1'b1;
        bus.imAddr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    endtask

    task automatic new_dm();
        bus.dmReq   = 1'b1;
        bus.dmWe    = 1'($urandom_range(0, 1));
        bus.dmAddr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        bus.dmWData = $urandom;
    endtask

    task automatic wait_ack(input bit is_dm, output int ac);
        bit got;
        got = 1'b0;
        ac  = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (is_dm ? bus.dmAck : bus.imAck) begin
                got = 1'b1;
                ac  = cyc;
            end
        end
        check_eq("ack_seen", got, 1);
    endtask

    task automatic wait_any(output bit port, output int ac);
        bit got;
        got  = 1'b0;
        ac   = -1;
        port = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.imAck || bus.dmAck) begin
                got  = 1'b1;
                ac   = cyc;
                port = bus.dmAck;
            end
        end
        check_eq("tie_ack_seen", got, 1);
    endtask

    initial begin
        int  c0, ac, prev_ac;
        bit  port, got;

        bus.imReq = 0; bus.imAddr = 0; bus.dmReq = 0; bus.dmWe = 0; bus.dmAddr = 0; bus.dmWData = 0;
        bus1.imReq = 0; bus1.imAddr = 0; bus1.dmReq = 0; bus1.dmWe = 0; bus1.dmAddr = 0; bus1.dmWData = 0;
        repeat (3) tick();
        reset = 1'b0; reset1 = 1'b0;

        repeat (10) tick();

        // Single fetch of a preloaded word
        c0 = cyc;
        bus.imReq = 1'b1; bus.imAddr = 32'h40;
        wait_ack(1'b0, ac);
        check_eq("fetch_latency", ac - c0, 4);
        check_eq("fetch_data", bus.imRData, 32'hDEADBEEF);
        tick();
        bus.imReq = 1'b0;
        repeat (2) tick();

        // Store then load back
        c0 = cyc;
        bus.dmReq = 1'b1; bus.dmWe = 1'b1; bus.dmAddr = 32'h80; bus.dmWData = 32'h12345678;
        wait_ack(1'b1, ac);
        check_eq("store_latency", ac - c0, 4);
        check_eq("store_rdata_kept", bus.dmRData, 0);
        tick();
        bus.dmReq = 1'b0; bus.dmWe = 1'b0;
        tick();
        c0 = cyc;
        bus.dmReq = 1'b1; bus.dmAddr = 32'h80;
        wait_ack(1'b1, ac);
        check_eq("load_latency", ac - c0, 4);
        check_eq("load_data", bus.dmRData, 32'h12345678);
        tick();
        bus.dmReq = 1'b0;
        repeat (2) tick();

        // Tie after reset: data wins first, then strict alternation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        c0 = cyc;
        new_im();
        bus.dmReq = 1'b1; bus.dmWe = 1'b0; bus.dmAddr = 32'h0C;
        prev_ac = c0;
        for (int k = 0; k < 4; k++) begin
            wait_any(port, ac);
            check_eq("tie_order", port, (k % 2 == 0) ? 1 : 0);
            check_eq("tie_spacing", ac - prev_ac, (k == 0) ? 4 : 5);
            prev_ac = ac;
            tick();
            if (port) new_dm(); else new_im();
        end
        bus.imReq = 1'b0; bus.dmReq = 1'b0;
        repeat (8) tick();

        // Reset while a fetch waits for memory
        c0 = cyc;
        bus.imReq = 1'b1; bus.imAddr = 32'h40;
        repeat (2) tick();
        reset = 1'b1; bus.imReq = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_ack", bus.imAck, 0);
        tick();
        c0 = cyc;
        bus.imReq = 1'b1; bus.imAddr = 32'h40;
        wait_ack(1'b0, ac);
        check_eq("refetch_latency", ac - c0, 4);
        check_eq("refetch_data", bus.imRData, 32'hDEADBEEF);
        tick();
        bus.imReq = 1'b0;
        repeat (2) tick();

        // Random traffic with occasional resets
        for (int t = 0; t < 1500; t++) begin
            if (bus.imReq) begin
                if (m_im_acked) begin
                    if ($urandom_range(0, 1) == 1) new_im(); else bus.imReq = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_im();
            end
            if (bus.dmReq) begin
                if (m_dm_acked) begin
                    if ($urandom_range(0, 1) == 1) new_dm(); else bus.dmReq = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_dm();
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1; bus.imReq = 1'b0; bus.dmReq = 1'b0;
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        reset = 1'b0; bus.imReq = 1'b0; bus.dmReq = 1'b0;
        repeat (8) tick();

        // LAT=1 instance: single load
        c0 = cyc;
        got = 1'b0;
        ac = -1;
        bus1.dmReq = 1'b1; bus1.dmWe = 1'b0; bus1.dmAddr = 32'h0C;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            check_eq("lat1_imAck", bus1.imAck, 0);
            if (bus1.dmAck) begin
                got = 1'b1;
                ac  = cyc;
                check_eq("lat1_data", bus1.dmRData, init_val(3));
                check_eq("lat1_busy", busy1, 1);
            end
        end
        check_eq("lat1_ack_seen", got, 1);
        check_eq("lat1_latency", ac - c0, 3);
        tick();
        bus1.dmReq = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
